pipeline_stall_ctrl: RTL

PIPELINE_STALL_CTRL -- requirements
Module: pipeline_stall_ctrl

---
 rtl/pipeline_stall_ctrl_pkg.sv | 19 +
 rtl/pipeline_stall_ctrl_sat_counter.sv | 27 ++
 rtl/pipeline_stall_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/pipeline_stall_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_types
//   Shared pipeline types for the RV32I core.
//   - stall_state_t : stall controller state (RUN / WAIT)
//   - IFID..MEMWB   : indices of the inter-stage buffers in buf_load/buf_bubble
// ---------------------------------------------------------------------------
package rv32i_types;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } stall_state_t;

  localparam int IFID  = 0;
  localparam int IDEX  = 1;
  localparam int EXMEM = 2;
  localparam int MEMWB = 3;

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
//   Event counter that sticks at its all-ones value instead of wrapping.
//   Ports:
//     clk   in  1      clock
//     rst   in  1      synchronous active-low reset (clears count)
//     inc   in  1      count one event this cycle
//     count out CNT_W  current count
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_stall_ctrl
//   Decides, every cycle, whether the pipeline steps forward, which
//   inter-stage buffers load, which of them load a NOP bubble, and keeps
//   stall / flush / load-use bubble counters.
//   A step completes once the instruction fetch has responded and, if the
//   EX/MEM instruction accesses memory, the data port has responded too.
//   Responses that arrive early are remembered so the port is not
//   re-requested while the other port is still pending.
//   Ports:
//     clk, rst                        clock, synchronous active-low reset
//     inst_mem_resp, data_mem_resp    memory port done strobes
//     exmem_mem_read/_write           EX/MEM instruction needs data access
//     idex_is_load, idex_rd           load in ID/EX and its destination
//     ifid_rs1/_rs2, ifid_rs*_used    sources of the instruction in IF/ID
//     redirect                        EX resolved a taken control transfer
//     inst_mem_read                   fetch request
//     data_mem_read, data_mem_write   data request
//     pc_load, pc_redirect            PC enable / select EX target
//     buf_load, buf_bubble            per-buffer load / load-a-NOP
//     stall_cycles, flush_count,
//     bubble_count                    saturating performance counters
// ---------------------------------------------------------------------------
module pipeline_stall_ctrl
  import rv32i_types::*;
#(
  parameter int NUM_BUF = 4,
  parameter int REG_W   = 5,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inst_mem_resp,
  input  logic               data_mem_resp,
  input  logic               exmem_mem_read,
  input  logic               exmem_mem_write,
  input  logic               idex_is_load,
  input  logic [REG_W-1:0]   idex_rd,
  input  logic [REG_W-1:0]   ifid_rs1,
  input  logic [REG_W-1:0]   ifid_rs2,
  input  logic               ifid_rs1_used,
  input  logic               ifid_rs2_used,
  input  logic               redirect,
  output logic               inst_mem_read,
  output logic               data_mem_read,
  output logic               data_mem_write,
  output logic               pc_load,
  output logic               pc_redirect,
  output logic [NUM_BUF-1:0] buf_load,
  output logic [NUM_BUF-1:0] buf_bubble,
  output logic [CNT_W-1:0]   stall_cycles,
  output logic [CNT_W-1:0]   flush_count,
  output logic [CNT_W-1:0]   bubble_count
);

  stall_state_t state_reg, state_next;
  logic inst_done_q, data_done_q;
  logic inst_done_next, data_done_next;
  logic data_need, advance, hazard;
  logic redirect_fire, hazard_fire;

  // Step completion is combinational so a response that lands on the final
  // cycle advances the pipeline immediately without touching the flags.
  always_comb begin
    data_need = exmem_mem_read | exmem_mem_write;
    advance   = (inst_done_q | inst_mem_resp) &
                (!data_need | data_done_q | data_mem_resp);
    hazard    = idex_is_load & (idex_rd != '0) &
                ((ifid_rs1_used & (ifid_rs1 == idex_rd)) |
                 (ifid_rs2_used & (ifid_rs2 == idex_rd)));
    redirect_fire = advance & redirect;
    hazard_fire   = advance & !redirect & hazard;
  end

  // Flags remember a response until the step completes; a response on an
  // already-flagged port changes nothing.
  always_comb begin
    inst_done_next = inst_done_q;
    data_done_next = data_done_q;
    if (advance) begin
      inst_done_next = 1'b0;
      data_done_next = 1'b0;
    end else begin
      if (inst_mem_resp) inst_done_next = 1'b1;
      if (data_mem_resp) data_done_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= RUN;
      inst_done_q <= 1'b0;
      data_done_q <= 1'b0;
    end else begin
      state_reg   <= state_next;
      inst_done_q <= inst_done_next;
      data_done_q <= data_done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:     if (!advance) state_next = WAIT;
      WAIT:    if (advance)  state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    inst_mem_read  = !inst_done_q;
    data_mem_read  = exmem_mem_read  & !data_done_q;
    data_mem_write = exmem_mem_write & !data_done_q;
    // A load-use hazard holds the PC and IF/ID while ID/EX takes a bubble.
    pc_load        = advance & !hazard_fire;
    pc_redirect    = redirect_fire;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BUF; gi++) begin : g_buf
      if (gi == IFID) begin : g_ifid
        assign buf_load[gi]   = advance & !hazard_fire;
        assign buf_bubble[gi] = redirect_fire;
      end else if (gi == IDEX) begin : g_idex
        assign buf_load[gi]   = advance;
        assign buf_bubble[gi] = redirect_fire | hazard_fire;
      end else begin : g_rest
        assign buf_load[gi]   = advance;
        assign buf_bubble[gi] = 1'b0;
      end
    end
  endgenerate

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (!advance),
    .count (stall_cycles)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (redirect_fire),
    .count (flush_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (hazard_fire),
    .count (bubble_count)
  );

endmodule
